// File: rtl/dcache_wb_axi_writer.sv
// dcache_wb_axi_writer: turns one dirty cache line into a single AXI4 INCR write burst and
// reports completion (done_o) and response error (err_o) back to the DCache miss/evict FSM.
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   req_valid_i/req_ready_o            writeback request handshake (ready only when idle)
//   req_addr_i, req_data_i             line address (low OFF bits ignored), line data (beat 0 in LSBs)
//   done_o, err_o                      1-cycle completion pulse, error flag valid with done_o
//   aw*_o, awready_i                   AXI write address channel
//   w*_o, wready_i                     AXI write data channel
//   bvalid_i/bready_o, bresp_i, bid_i  AXI write response channel
module dcache_wb_axi_writer #(
    parameter int LINE_WIDTH = 256,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int AXI_ID_WIDTH = 4,
    parameter logic [AXI_ID_WIDTH-1:0] AXI_ID = '0
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [ADDR_WIDTH-1:0]       req_addr_i,
    input  logic [LINE_WIDTH-1:0]       req_data_i,
    output logic                        done_o,
    output logic                        err_o,
    output logic                        awvalid_o,
    input  logic                        awready_i,
    output logic [ADDR_WIDTH-1:0]       awaddr_o,
    output logic [7:0]                  awlen_o,
    output logic [2:0]                  awsize_o,
    output logic [1:0]                  awburst_o,
    output logic [AXI_ID_WIDTH-1:0]     awid_o,
    output logic                        wvalid_o,
    input  logic                        wready_i,
    output logic [AXI_DATA_WIDTH-1:0]   wdata_o,
    output logic [AXI_DATA_WIDTH/8-1:0] wstrb_o,
    output logic                        wlast_o,
    input  logic                        bvalid_i,
    output logic                        bready_o,
    input  logic [1:0]                  bresp_i,
    input  logic [AXI_ID_WIDTH-1:0]     bid_i
);
    localparam int BEATS = LINE_WIDTH / AXI_DATA_WIDTH;
    localparam int OFF = $clog2(LINE_WIDTH / 8);
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [ADDR_WIDTH-1:0] AMASK = ~ADDR_WIDTH'((64'd1 << OFF) - 64'd1);

    typedef enum logic [1:0] {IDLE, SEND, RESP} state_t;

    state_t state, state_n;
    logic [BEATS-1:0][AXI_DATA_WIDTH-1:0] line;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BW-1:0] beat;
    logic aw_done, w_done;
    logic accept, aw_hs, w_hs, w_last_hs;

    assign req_ready_o = state == IDLE;
    assign accept = req_valid_i & req_ready_o;
    assign aw_hs = awvalid_o & awready_i;
    assign w_hs = wvalid_o & wready_i;
    assign w_last_hs = w_hs & wlast_o;
    assign bready_o = state == RESP;
    assign done_o = bready_o & bvalid_i;
    assign err_o = done_o & ((bresp_i != 2'b00) | (bid_i != AXI_ID));

    assign awaddr_o = addr;
    assign awlen_o = 8'(BEATS - 1);
    assign awsize_o = 3'($clog2(AXI_DATA_WIDTH / 8));
    assign awburst_o = 2'b01;
    assign awid_o = AXI_ID;
    assign wdata_o = line[beat];
    assign wstrb_o = '1;
    assign wlast_o = beat == BW'(BEATS - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else state <= state_n;
    end

    // AW and W complete independently; the response phase starts only once both have.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = accept ? SEND : IDLE;
            SEND: state_n = ((aw_done | aw_hs) & (w_done | w_last_hs)) ? RESP : SEND;
            RESP: state_n = done_o ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            awvalid_o <= 1'b0;
            wvalid_o <= 1'b0;
            beat <= '0;
            aw_done <= 1'b0;
            w_done <= 1'b0;
        end else if (accept) begin
            awvalid_o <= 1'b1;
            wvalid_o <= 1'b1;
            beat <= '0;
            aw_done <= 1'b0;
            w_done <= 1'b0;
        end else begin
            if (aw_hs) begin
                awvalid_o <= 1'b0;
                aw_done <= 1'b1;
            end
            if (w_hs && !wlast_o) beat <= beat + BW'(1);
            if (w_last_hs) begin
                wvalid_o <= 1'b0;
                w_done <= 1'b1;
            end
        end
    end

    // Datapath needs no reset: it is only observable after a capture.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            line <= req_data_i;
            addr <= req_addr_i & AMASK;
        end
    end
endmodule

// File: tb/tb_dcache_wb_axi_writer.sv
// tb_dcache_wb_axi_writer: self-checking bench for dcache_wb_axi_writer with randomized
// AXI backpressure; a negedge monitor logs handshakes, expectations come from the line contents.
module tb_dcache_wb_axi_writer;
    logic clk = 0;
    logic rst_ni;
    logic req_valid_i, req_ready_o;
    logic [31:0] req_addr_i;
    logic [255:0] req_data_i;
    logic done_o, err_o;
    logic awvalid_o, awready_i;
    logic [31:0] awaddr_o;
    logic [7:0] awlen_o;
    logic [2:0] awsize_o;
    logic [1:0] awburst_o;
    logic [3:0] awid_o;
    logic wvalid_o, wready_i;
    logic [31:0] wdata_o;
    logic [3:0] wstrb_o;
    logic wlast_o;
    logic bvalid_i, bready_o;
    logic [1:0] bresp_i;
    logic [3:0] bid_i;

    int checks = 0;
    int failures = 0;

    dcache_wb_axi_writer dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i),
        .done_o(done_o), .err_o(err_o),
        .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o),
        .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o), .awid_o(awid_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o),
        .wstrb_o(wstrb_o), .wlast_o(wlast_o),
        .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i), .bid_i(bid_i)
    );

    always #5 clk = ~clk;

    // Monitor: records every handshake with its cycle number, plus protocol-rule violations.
    int cyc = 0;
    logic [31:0] aw_q[$];
    int aw_cyc_q[$];
    logic [31:0] w_q[$];
    logic wl_q[$];
    int wc_q[$];
    logic d_q[$];
    int dc_q[$];
    int acc_q[$];
    int stab_err = 0, err_stray = 0, bready_early = 0, rr_bad = 0;
    logic busy = 0, aw_pend = 0, pa = 0, pw = 0, plast = 0;
    int w_left = 0;
    logic [31:0] paddr, pdata;

    always @(negedge clk) begin
        cyc++;
        if (!rst_ni) begin
            busy = 0; aw_pend = 0; w_left = 0; pa = 0; pw = 0;
        end else begin
            if (pa && (!awvalid_o || awaddr_o !== paddr)) stab_err++;
            if (pw && (!wvalid_o || wdata_o !== pdata || wlast_o !== plast)) stab_err++;
            pa = awvalid_o && !awready_i; paddr = awaddr_o;
            pw = wvalid_o && !wready_i; pdata = wdata_o; plast = wlast_o;
            if (awvalid_o && awready_i) begin
                aw_q.push_back(awaddr_o); aw_cyc_q.push_back(cyc); aw_pend = 0;
            end
            if (wvalid_o && wready_i) begin
                w_q.push_back(wdata_o); wl_q.push_back(wlast_o); wc_q.push_back(cyc); w_left--;
            end
            if (err_o && !done_o) err_stray++;
            if (bready_o && (aw_pend || w_left > 0)) bready_early++;
            if (busy && req_ready_o) rr_bad++;
            if (done_o) begin
                d_q.push_back(err_o); dc_q.push_back(cyc); busy = 0;
            end
            if (req_valid_i && req_ready_o) begin
                acc_q.push_back(cyc); busy = 1; aw_pend = 1; w_left = 8;
            end
        end
    end

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // Drives one request and the slave side until done_o. aw_delay<0 holds awready low
    // until all eight W beats have been accepted.
    task automatic run_burst(input logic [31:0] a, input logic [255:0] l, input int aw_delay,
                             input int wprob, input logic [1:0] br, input logic [3:0] bi);
        int n, wb, nd, t;
        wb = w_q.size();
        nd = d_q.size();
        n = 0;
        @(posedge clk); #1;
        req_valid_i = 1; req_addr_i = a; req_data_i = l;
        bresp_i = br; bid_i = bi; awready_i = 0; wready_i = 0; bvalid_i = 0;
        t = 0;
        do begin @(negedge clk); t++; end while (!req_ready_o && t < 50);
        @(posedge clk); #1;
        req_valid_i = 0; req_addr_i = $urandom; req_data_i = rand_line();
        for (t = 0; t < 400 && d_q.size() == nd; t++) begin
            awready_i = aw_delay < 0 ? (w_q.size() - wb >= 8) : (n >= aw_delay);
            wready_i = $urandom_range(0, 99) < wprob;
            bvalid_i = 1;
            @(negedge clk); #1;
            n++;
            if (d_q.size() == nd) begin @(posedge clk); #1; end
        end
        checks++;
        if (d_q.size() == nd) begin
            failures++; $display("FAIL burst_timeout done=%0d required=1", d_q.size() - nd);
        end
        @(posedge clk); #1;
        bvalid_i = 0; awready_i = 0; wready_i = 0;
    endtask

    task automatic test_reset;
        rst_ni = 0; req_valid_i = 0; req_addr_i = 0; req_data_i = 0;
        awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0; bid_i = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready_o, awvalid_o, wvalid_o, bready_o, done_o, err_o} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_outputs got=%b required=100000",
                     {req_ready_o, awvalid_o, wvalid_o, bready_o, done_o, err_o});
        end
        #2 rst_ni = 1;
        @(posedge clk); #1 bvalid_i = 1; bresp_i = 2'b10;
        @(negedge clk);
        checks++;
        if ({bready_o, done_o, err_o} !== 3'b000) begin
            failures++; $display("FAIL idle_b_ignored got=%b required=000", {bready_o, done_o, err_o});
        end
        @(posedge clk); #1 bvalid_i = 0; bresp_i = 0;
    endtask

    task automatic test_ready_always;
        logic [255:0] l;
        int wb, ab, db, cb, acc;
        for (int k = 1; k <= 8; k++) l[(k-1)*32 +: 32] = 32'h11111111 * k;
        wb = w_q.size(); ab = aw_q.size(); db = d_q.size(); cb = acc_q.size();
        run_burst(32'h8000_1234, l, 0, 100, 2'b00, 4'd0);
        acc = acc_q[cb];
        checks++;
        if (aw_q.size() != ab + 1 || aw_q[ab] !== 32'h8000_1220) begin
            failures++; $display("FAIL t1_awaddr got=%h required=80001220", aw_q[ab]);
        end
        checks++;
        if ({awlen_o, awsize_o, awburst_o, awid_o, wstrb_o} !== {8'd7, 3'd2, 2'd1, 4'd0, 4'hf}) begin
            failures++;
            $display("FAIL t1_aw_attrs got len=%0d size=%0d burst=%0d id=%0d strb=%h required 7/2/1/0/f",
                     awlen_o, awsize_o, awburst_o, awid_o, wstrb_o);
        end
        checks++;
        if (aw_cyc_q[ab] != acc + 1) begin
            failures++; $display("FAIL t1_aw_cycle got=%0d required=1", aw_cyc_q[ab] - acc);
        end
        checks++;
        if (w_q.size() != wb + 8) begin
            failures++; $display("FAIL t1_wcount got=%0d required=8", w_q.size() - wb);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (w_q[wb+i] !== 32'h11111111 * (i + 1) || wl_q[wb+i] !== (i == 7) || wc_q[wb+i] != acc + 1 + i) begin
                failures++;
                $display("FAIL t1_beat%0d got data=%h last=%b cyc=%0d required data=%h last=%b cyc=%0d",
                         i, w_q[wb+i], wl_q[wb+i], wc_q[wb+i] - acc, 32'h11111111 * (i + 1), i == 7, i + 1);
            end
        end
        checks++;
        if (dc_q[db] != acc + 9 || d_q[db] !== 1'b0) begin
            failures++; $display("FAIL t1_done got cyc=%0d err=%b required cyc=9 err=0",
                                 dc_q[db] - acc, d_q[db]);
        end
    endtask

    task automatic test_backpressure;
        logic [255:0] l;
        logic [31:0] a;
        int wb, ab, sb;
        for (int n = 0; n < 4; n++) begin
            l = rand_line(); a = $urandom;
            wb = w_q.size(); ab = aw_q.size(); sb = stab_err;
            run_burst(a, l, 5, 50, 2'b00, 4'd0);
            checks++;
            if (aw_q.size() != ab + 1 || aw_q[ab] !== {a[31:5], 5'b0}) begin
                failures++; $display("FAIL t2_aw n=%0d count=%0d addr=%h required count=1 addr=%h",
                                     n, aw_q.size() - ab, aw_q[ab], {a[31:5], 5'b0});
            end
            checks++;
            if (w_q.size() != wb + 8) begin
                failures++; $display("FAIL t2_wcount n=%0d got=%0d required=8", n, w_q.size() - wb);
            end
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (w_q[wb+i] !== l[i*32 +: 32] || wl_q[wb+i] !== (i == 7)) begin
                    failures++; $display("FAIL t2_beat%0d got=%h/%b required=%h/%b",
                                         i, w_q[wb+i], wl_q[wb+i], l[i*32 +: 32], i == 7);
                end
            end
            checks++;
            if (stab_err != sb) begin
                failures++; $display("FAIL t2_stable violations=%0d required=0", stab_err - sb);
            end
        end
    endtask

    task automatic test_w_before_aw;
        logic [255:0] l;
        int wb, ab, db, eb;
        l = rand_line();
        wb = w_q.size(); ab = aw_q.size(); db = d_q.size(); eb = bready_early;
        run_burst($urandom, l, -1, 100, 2'b00, 4'd0);
        checks++;
        if (aw_q.size() != ab + 1 || w_q.size() != wb + 8 || aw_cyc_q[ab] <= wc_q[wb+7]) begin
            failures++; $display("FAIL t3_order aw_cyc=%0d last_w_cyc=%0d required aw after last W",
                                 aw_cyc_q[ab], wc_q[wb+7]);
        end
        checks++;
        if (dc_q[db] != aw_cyc_q[ab] + 1) begin
            failures++; $display("FAIL t3_resp_entry got=%0d required=1 cycle after AW",
                                 dc_q[db] - aw_cyc_q[ab]);
        end
        checks++;
        if (bready_early != eb) begin
            failures++; $display("FAIL t3_bready_early got=%0d required=0", bready_early - eb);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (w_q[wb+i] !== l[i*32 +: 32]) begin
                failures++; $display("FAIL t3_beat%0d got=%h required=%h", i, w_q[wb+i], l[i*32 +: 32]);
            end
        end
    endtask

    task automatic test_error;
        logic [1:0] br;
        logic [3:0] bi;
        int db, sb;
        sb = err_stray;
        for (int n = 0; n < 7; n++) begin
            br = n == 0 ? 2'b10 : n == 1 ? 2'b00 : n == 2 ? 2'b00 : 2'($urandom);
            bi = n == 1 ? 4'd3 : n == 2 ? 4'd0 : 4'($urandom_range(0, 1) ? 0 : $urandom);
            db = d_q.size();
            run_burst($urandom, rand_line(), $urandom_range(0, 3), 80, br, bi);
            checks++;
            if (d_q[db] !== ((br != 2'b00) || (bi != 4'd0))) begin
                failures++; $display("FAIL t4_err bresp=%0d bid=%0d got=%b required=%b",
                                     br, bi, d_q[db], (br != 2'b00) || (bi != 4'd0));
            end
            checks++;
            if ({done_o, err_o} !== 2'b00 || d_q.size() != db + 1) begin
                failures++; $display("FAIL t4_pulse got done=%b err=%b dones=%0d required 0/0/1",
                                     done_o, err_o, d_q.size() - db);
            end
        end
        checks++;
        if (err_stray != sb) begin
            failures++; $display("FAIL t4_err_without_done got=%0d required=0", err_stray - sb);
        end
    endtask

    task automatic test_back_to_back;
        logic [255:0] la, lb;
        int wb, ab, db, rb, t;
        la = rand_line(); lb = rand_line();
        wb = w_q.size(); ab = acc_q.size(); db = d_q.size(); rb = rr_bad;
        @(posedge clk); #1;
        req_valid_i = 1; req_addr_i = $urandom; req_data_i = la;
        awready_i = 1; wready_i = 1; bvalid_i = 1; bresp_i = 0; bid_i = 0;
        t = 0;
        while (acc_q.size() == ab && t < 20) begin @(negedge clk); #1; t++; end
        @(posedge clk); #1;
        req_data_i = lb; req_addr_i = $urandom;
        t = 0;
        while (acc_q.size() < ab + 2 && t < 100) begin @(negedge clk); #1; t++; end
        @(posedge clk); #1;
        req_valid_i = 0; req_data_i = rand_line();
        t = 0;
        while (d_q.size() < db + 2 && t < 100) begin @(negedge clk); #1; t++; end
        @(posedge clk); #1;
        awready_i = 0; wready_i = 0; bvalid_i = 0;
        checks++;
        if (acc_q.size() != ab + 2 || d_q.size() != db + 2) begin
            failures++; $display("FAIL t5_counts accepts=%0d dones=%0d required 2/2",
                                 acc_q.size() - ab, d_q.size() - db);
        end
        checks++;
        if (acc_q[ab+1] != dc_q[db] + 1) begin
            failures++; $display("FAIL t5_reaccept got=%0d required=1 cycle after done",
                                 acc_q[ab+1] - dc_q[db]);
        end
        checks++;
        if (rr_bad != rb) begin
            failures++; $display("FAIL t5_req_ready_busy got=%0d required=0", rr_bad - rb);
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (w_q[wb+i] !== (i < 8 ? la[i*32 +: 32] : lb[(i-8)*32 +: 32])) begin
                failures++; $display("FAIL t5_beat%0d got=%h required=%h", i, w_q[wb+i],
                                     i < 8 ? la[i*32 +: 32] : lb[(i-8)*32 +: 32]);
            end
        end
    endtask

    task automatic test_reset_mid_burst;
        logic [255:0] l;
        int wb, t;
        l = rand_line();
        wb = w_q.size();
        @(posedge clk); #1;
        req_valid_i = 1; req_addr_i = $urandom; req_data_i = l;
        awready_i = 0; wready_i = 0; bvalid_i = 0;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid_i = 0; wready_i = 1; bvalid_i = 1;
        t = 0;
        while (w_q.size() - wb < 4 && t < 50) begin @(negedge clk); #1; t++; end
        checks++;
        if (w_q.size() - wb != 4 || !awvalid_o || !wvalid_o) begin
            failures++; $display("FAIL t6_pre_reset beats=%0d aw=%b w=%b required 4/1/1",
                                 w_q.size() - wb, awvalid_o, wvalid_o);
        end
        rst_ni = 0;
        #1;
        checks++;
        if ({awvalid_o, wvalid_o, bready_o} !== 3'b000) begin
            failures++; $display("FAIL t6_async_drop got=%b required=000", {awvalid_o, wvalid_o, bready_o});
        end
        wready_i = 0; bvalid_i = 0;
        repeat (2) @(posedge clk);
        #2 rst_ni = 1;
        @(negedge clk);
        checks++;
        if (req_ready_o !== 1'b1) begin
            failures++; $display("FAIL t6_ready_after_reset got=%b required=1", req_ready_o);
        end
        l = rand_line();
        wb = w_q.size();
        run_burst($urandom, l, 0, 100, 2'b00, 4'd0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (w_q[wb+i] !== l[i*32 +: 32]) begin
                failures++; $display("FAIL t6_fresh_beat%0d got=%h required=%h", i, w_q[wb+i], l[i*32 +: 32]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ready_always();
        test_backpressure();
        test_w_before_aw();
        test_error();
        test_back_to_back();
        test_reset_mid_burst();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
